// File: rtl/addr_gen_pkg.sv
// Shared definitions for the multi-channel address generator: command op codes
// and controller state encoding.
package addr_gen_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 3'd0,
    OP_WRES = 3'd1,
    OP_WERR = 3'd2,
    OP_CONV = 3'd3,
    OP_CLR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_CLR  = 2'd2
  } state_e;

endpackage

// File: rtl/addr_gen_vec_regs.sv
// Per-vector allocation records with circular head pointer and stage counter.
// One combinational read port; head/stage writes target the read-port id.
module addr_gen_vec_regs #(
  parameter int unsigned NUM_VEC        = 12,
  parameter int unsigned VEC_ID_W       = 4,
  parameter int unsigned STAGE_W        = 3,
  parameter int unsigned DATA_ADDR_W    = 12,
  parameter int unsigned ALLOC_LEN_W    = 10,
  parameter int unsigned REGFILE_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [VEC_ID_W-1:0]       cfg_id,
  input  logic [DATA_ADDR_W-1:0]    cfg_data_ptr,
  input  logic [DATA_ADDR_W-1:0]    cfg_coef_ptr,
  input  logic [ALLOC_LEN_W-1:0]    cfg_len,
  input  logic [STAGE_W-1:0]        cfg_stgs,
  input  logic [REGFILE_ADDR_W-1:0] cfg_resreg,
  input  logic [REGFILE_ADDR_W-1:0] cfg_errreg,
  input  logic                      clr_all,
  input  logic [VEC_ID_W-1:0]       rd_id,
  input  logic                      head_we,
  input  logic [DATA_ADDR_W-1:0]    head_wdata,
  input  logic                      stage_we,
  input  logic [STAGE_W-1:0]        stage_wdata,
  output logic                      rd_cfgd,
  output logic [DATA_ADDR_W-1:0]    rd_data_ptr,
  output logic [DATA_ADDR_W-1:0]    rd_coef_ptr,
  output logic [ALLOC_LEN_W-1:0]    rd_len,
  output logic [STAGE_W-1:0]        rd_stgs,
  output logic [REGFILE_ADDR_W-1:0] rd_resreg,
  output logic [REGFILE_ADDR_W-1:0] rd_errreg,
  output logic [DATA_ADDR_W-1:0]    rd_head,
  output logic [STAGE_W-1:0]        rd_stage
);

  logic                      cfgd_r     [NUM_VEC];
  logic [DATA_ADDR_W-1:0]    data_ptr_r [NUM_VEC];
  logic [DATA_ADDR_W-1:0]    coef_ptr_r [NUM_VEC];
  logic [ALLOC_LEN_W-1:0]    len_r      [NUM_VEC];
  logic [STAGE_W-1:0]        stgs_r     [NUM_VEC];
  logic [REGFILE_ADDR_W-1:0] resreg_r   [NUM_VEC];
  logic [REGFILE_ADDR_W-1:0] errreg_r   [NUM_VEC];
  logic [DATA_ADDR_W-1:0]    head_r     [NUM_VEC];
  logic [STAGE_W-1:0]        stage_r    [NUM_VEC];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
        cfgd_r[i]     <= 1'b0;
        data_ptr_r[i] <= '0;
        coef_ptr_r[i] <= '0;
        len_r[i]      <= '0;
        stgs_r[i]     <= '0;
        resreg_r[i]   <= '0;
        errreg_r[i]   <= '0;
        head_r[i]     <= '0;
        stage_r[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
        if (cfg_we && cfg_id == VEC_ID_W'(i)) begin
          cfgd_r[i]     <= 1'b1;
          data_ptr_r[i] <= cfg_data_ptr;
          coef_ptr_r[i] <= cfg_coef_ptr;
          len_r[i]      <= cfg_len;
          stgs_r[i]     <= cfg_stgs;
          resreg_r[i]   <= cfg_resreg;
          errreg_r[i]   <= cfg_errreg;
          head_r[i]     <= cfg_data_ptr;
          stage_r[i]    <= '0;
        end else if (clr_all) begin
          head_r[i]  <= data_ptr_r[i];
          stage_r[i] <= '0;
        end else begin
          if (head_we && rd_id == VEC_ID_W'(i))
            head_r[i] <= head_wdata;
          if (stage_we && rd_id == VEC_ID_W'(i))
            stage_r[i] <= stage_wdata;
        end
      end
    end
  end

  // Out-of-range ids read as an unconfigured all-zero record.
  always_comb begin
    rd_cfgd     = 1'b0;
    rd_data_ptr = '0;
    rd_coef_ptr = '0;
    rd_len      = '0;
    rd_stgs     = '0;
    rd_resreg   = '0;
    rd_errreg   = '0;
    rd_head     = '0;
    rd_stage    = '0;
    if (32'(rd_id) < NUM_VEC) begin
      rd_cfgd     = cfgd_r[rd_id];
      rd_data_ptr = data_ptr_r[rd_id];
      rd_coef_ptr = coef_ptr_r[rd_id];
      rd_len      = len_r[rd_id];
      rd_stgs     = stgs_r[rd_id];
      rd_resreg   = resreg_r[rd_id];
      rd_errreg   = errreg_r[rd_id];
      rd_head     = head_r[rd_id];
      rd_stage    = stage_r[rd_id];
    end
  end

endmodule

// File: rtl/addr_gen_mc.sv
// Multi-channel address generator: executes vector commands, streams CONV
// address pairs with backpressure and runs a full-RAM clear sweep.
module addr_gen_mc
  import addr_gen_pkg::*;
#(
  parameter int unsigned NUM_VEC        = 12,
  parameter int unsigned VEC_ID_W       = 4,
  parameter int unsigned STAGE_W        = 3,
  parameter int unsigned DATA_ADDR_W    = 12,
  parameter int unsigned ALLOC_LEN_W    = 10,
  parameter int unsigned REGFILE_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [VEC_ID_W-1:0]       cfg_id,
  input  logic [DATA_ADDR_W-1:0]    cfg_data_ptr,
  input  logic [DATA_ADDR_W-1:0]    cfg_coef_ptr,
  input  logic [ALLOC_LEN_W-1:0]    cfg_len,
  input  logic [STAGE_W-1:0]        cfg_stgs,
  input  logic [REGFILE_ADDR_W-1:0] cfg_resreg,
  input  logic [REGFILE_ADDR_W-1:0] cfg_errreg,
  output logic                      cfg_err,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OP_W-1:0]           cmd_op,
  input  logic [VEC_ID_W-1:0]       cmd_id,
  output logic                      cmd_err,
  output logic                      addr_valid,
  input  logic                      addr_ready,
  output logic                      addr_last,
  output logic [DATA_ADDR_W-1:0]    ram_addr_a,
  output logic [DATA_ADDR_W-1:0]    ram_addr_b,
  output logic                      mem_clr_we,
  output logic                      mrst_done,
  output logic [REGFILE_ADDR_W-1:0] raddr_a,
  output logic [REGFILE_ADDR_W-1:0] raddr_b,
  output logic [REGFILE_ADDR_W-1:0] raddr_d,
  output logic [STAGE_W-1:0]        stage_cnt
);

  localparam logic [DATA_ADDR_W-1:0] A_ONE = 1;
  localparam logic [STAGE_W-1:0]     S_ONE = 1;

  state_e                  state;
  op_e                     op;
  logic [DATA_ADDR_W-1:0]  a_q, b_q, dptr_q, dend_q, cend_q;
  logic                    cfg_ok, fire, cmd_ok, head_we, stage_we, clr_all;
  logic [DATA_ADDR_W-1:0]  rd_dend, rd_cend, head_nxt;
  logic [STAGE_W-1:0]      stage_nxt;

  logic                      rd_cfgd;
  logic [DATA_ADDR_W-1:0]    rd_data_ptr, rd_coef_ptr, rd_head;
  logic [ALLOC_LEN_W-1:0]    rd_len;
  logic [STAGE_W-1:0]        rd_stgs, rd_stage;
  logic [REGFILE_ADDR_W-1:0] rd_resreg, rd_errreg;

  assign op         = op_e'(cmd_op);
  assign cmd_ready  = (state == S_IDLE) && !cfg_we;
  assign ram_addr_a = a_q;
  assign ram_addr_b = b_q;

  always_comb begin
    cfg_ok    = cfg_we && (state == S_IDLE) && (32'(cfg_id) < NUM_VEC) && (cfg_len != '0);
    fire      = cmd_valid && cmd_ready;
    rd_dend   = rd_data_ptr + DATA_ADDR_W'(rd_len) - A_ONE;
    rd_cend   = rd_coef_ptr + DATA_ADDR_W'(rd_len) - A_ONE;
    head_nxt  = (rd_head == rd_dend) ? rd_data_ptr : rd_head + A_ONE;
    stage_nxt = (rd_stage == rd_stgs) ? '0 : rd_stage + S_ONE;
    // CLR needs no vector; every other defined op needs a configured one.
    case (op)
      OP_LOAD, OP_WRES, OP_WERR, OP_CONV: cmd_ok = (32'(cmd_id) < NUM_VEC) && rd_cfgd;
      OP_CLR:                             cmd_ok = 1'b1;
      default:                            cmd_ok = 1'b0;
    endcase
    head_we  = fire && cmd_ok && (op == OP_WRES);
    stage_we = fire && cmd_ok && (op == OP_WERR);
    clr_all  = (state == S_CLR) && (a_q == '1);
  end

  addr_gen_vec_regs #(
    .NUM_VEC        (NUM_VEC),
    .VEC_ID_W       (VEC_ID_W),
    .STAGE_W        (STAGE_W),
    .DATA_ADDR_W    (DATA_ADDR_W),
    .ALLOC_LEN_W    (ALLOC_LEN_W),
    .REGFILE_ADDR_W (REGFILE_ADDR_W)
  ) u_regs (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_ok),
    .cfg_id       (cfg_id),
    .cfg_data_ptr (cfg_data_ptr),
    .cfg_coef_ptr (cfg_coef_ptr),
    .cfg_len      (cfg_len),
    .cfg_stgs     (cfg_stgs),
    .cfg_resreg   (cfg_resreg),
    .cfg_errreg   (cfg_errreg),
    .clr_all      (clr_all),
    .rd_id        (cmd_id),
    .head_we      (head_we),
    .head_wdata   (head_nxt),
    .stage_we     (stage_we),
    .stage_wdata  (stage_nxt),
    .rd_cfgd      (rd_cfgd),
    .rd_data_ptr  (rd_data_ptr),
    .rd_coef_ptr  (rd_coef_ptr),
    .rd_len       (rd_len),
    .rd_stgs      (rd_stgs),
    .rd_resreg    (rd_resreg),
    .rd_errreg    (rd_errreg),
    .rd_head      (rd_head),
    .rd_stage     (rd_stage)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      dptr_q     <= '0;
      dend_q     <= '0;
      cend_q     <= '0;
      cfg_err    <= 1'b0;
      cmd_err    <= 1'b0;
      addr_valid <= 1'b0;
      addr_last  <= 1'b0;
      mem_clr_we <= 1'b0;
      mrst_done  <= 1'b0;
      raddr_a    <= '0;
      raddr_b    <= '0;
      raddr_d    <= '0;
      stage_cnt  <= '0;
    end else begin
      cfg_err   <= cfg_we && !cfg_ok;
      cmd_err   <= 1'b0;
      mrst_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fire) begin
            if (!cmd_ok) begin
              cmd_err <= 1'b1;
            end else begin
              case (op)
                OP_LOAD: begin
                  raddr_a   <= rd_resreg;
                  raddr_b   <= rd_errreg;
                  stage_cnt <= rd_stage;
                end
                OP_WRES: begin
                  raddr_d   <= rd_resreg;
                  stage_cnt <= rd_stage;
                end
                OP_WERR: begin
                  raddr_d   <= rd_errreg;
                  stage_cnt <= stage_nxt;
                end
                OP_CONV: begin
                  a_q        <= rd_head;
                  b_q        <= rd_coef_ptr;
                  dptr_q     <= rd_data_ptr;
                  dend_q     <= rd_dend;
                  cend_q     <= rd_cend;
                  addr_valid <= 1'b1;
                  addr_last  <= (rd_coef_ptr == rd_cend);
                  stage_cnt  <= rd_stage;
                  state      <= S_CONV;
                end
                OP_CLR: begin
                  a_q        <= '0;
                  mem_clr_we <= 1'b1;
                  state      <= S_CLR;
                end
                default: ;
              endcase
            end
          end
        end
        S_CONV: begin
          if (addr_valid && addr_ready) begin
            if (addr_last) begin
              addr_valid <= 1'b0;
              addr_last  <= 1'b0;
              state      <= S_IDLE;
            end else begin
              // Data walks backwards through the circular buffer, coefs forwards.
              a_q       <= (a_q == dptr_q) ? dend_q : a_q - A_ONE;
              b_q       <= b_q + A_ONE;
              addr_last <= (b_q + A_ONE == cend_q);
            end
          end
        end
        S_CLR: begin
          if (a_q == '1) begin
            mem_clr_we <= 1'b0;
            mrst_done  <= 1'b1;
            stage_cnt  <= '0;
            state      <= S_IDLE;
          end else begin
            a_q <= a_q + A_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/addr_gen_mc.md
Name: addr_gen_mc

Overview:
Multi-channel address generator for the sample-rate-converter datapath. It holds per-vector allocation records for up to NUM_VEC data/coefficient vectors, each with a circular head pointer and a stage counter. It executes commands through a valid/ready handshake and streams RAM address pairs for convolution with backpressure. It also runs a full-RAM clear sweep, and sits between the sequencer, the data/coef RAMs, the MAC and the register file.

Parameters:
NUM_VEC, 12, number of vector channels
VEC_ID_W, 4, vector id width (2^VEC_ID_W >= NUM_VEC)
STAGE_W, 3, stage counter width
DATA_ADDR_W, 12, RAM address width
ALLOC_LEN_W, 10, vector length width
REGFILE_ADDR_W, 5, register file address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  config write strobe
cfg_id  in  VEC_ID_W  vector being configured
cfg_data_ptr, cfg_coef_ptr  in  DATA_ADDR_W  base addresses of the data and coefficient arrays
cfg_len  in  ALLOC_LEN_W  vector length
cfg_stgs  in  STAGE_W  last stage index
cfg_resreg, cfg_errreg  in  REGFILE_ADDR_W  result and error registers
cfg_err  out  1  one-cycle pulse when a config write is rejected
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_op  in  3  0=LOAD 1=WRES 2=WERR 3=CONV 4=CLR, others reserved
cmd_id  in  VEC_ID_W  target vector
cmd_err  out  1  one-cycle pulse when an accepted command is invalid
addr_valid  out  1  address pair valid
addr_ready  in  1  consumer ready
addr_last  out  1  final beat of a CONV
ram_addr_a, ram_addr_b  out  DATA_ADDR_W  data and coefficient addresses
mem_clr_we  out  1  clear-write strobe (address on ram_addr_a)
mrst_done  out  1  one-cycle pulse when CLR completes
raddr_a, raddr_b, raddr_d  out  REGFILE_ADDR_W  register file addresses
stage_cnt  out  STAGE_W  stage counter of the last commanded vector

Behaviour:
- Reset, synchronous: all outputs 0. FSM goes to IDLE. All per-vector records, heads, stage counters and configured bits go to 0. A reset mid-CONV or mid-CLR aborts, and addr_valid/mem_clr_we are 0 the next cycle.
- FSM states: IDLE, CONV, CLR. cmd_ready = (state==IDLE) && !cfg_we, so a config write and a command never coincide.
- Config write: accepted only in IDLE, with cfg_id < NUM_VEC and cfg_len != 0. It stores the record, sets head = cfg_data_ptr, stage = 0 and configured = 1. Any other config write is dropped and pulses cfg_err.
- Command handshake: cmd_valid && cmd_ready. Reserved op, cmd_id >= NUM_VEC, or an unconfigured vector: the command is consumed with no effect and cmd_err pulses on the next cycle.
- Pointer definitions: data_end = data_ptr + len - 1 and coef_end = coef_ptr + len - 1, both mod 2^DATA_ADDR_W.
- LOAD: raddr_a <= resreg, raddr_b <= errreg next cycle; stays in IDLE.
- WRES: raddr_d <= resreg. head <= (head == data_end) ? data_ptr : head + 1.
- WERR: raddr_d <= errreg. stage <= (stage == stgs) ? 0 : stage + 1. stage_cnt shows the new value.
- CONV handshake: if accepted in cycle N, first beat has addr_valid=1 at N+1 with ram_addr_a = head, ram_addr_b = coef_ptr.
- CONV advance: on each addr_valid && addr_ready, a <= (a == data_ptr) ? data_end : a - 1 and b <= b + 1. Exactly len beats are produced.
- CONV last beat: addr_last = 1 only with the last beat, where b == coef_end. After the last handshake, addr_valid = 0 and IDLE is reached the next cycle.
- CONV stall: outputs hold stable while addr_valid && !addr_ready.
- CLR sweep: ram_addr_a runs 0 .. 2^DATA_ADDR_W - 1, one address per cycle with mem_clr_we = 1. There is no backpressure.
- CLR completion: the cycle after the last address, mem_clr_we = 0 and mrst_done pulses. Every head returns to its data_ptr, all stages go to 0, and the FSM returns to IDLE. Config records are kept.

Decomposition:
- addr_gen_pkg: op codes, FSM state encoding, width-derived constants.
- Sub-module addr_gen_vec_regs: per-vector records, head and stage storage, with one read port (cmd_id / active id) and write ports for config, head and stage.

Test Plan:
- Basic CONV: configure id2 with data_ptr=0x100, len=4, coef_ptr=0x800, stgs=2; issue 2×WRES then CONV. Required: head = 0x102; a = 0x102, 0x101, 0x100, 0x103; b = 0x800..0x803; addr_last on beat 4 only.
- Backpressure: same CONV with addr_ready low for 3 cycles at beat 2. Required: a=0x101 and b=0x801 held; still exactly 4 beats.
- Head wrap and stage wrap: 4×WRES from head 0x100 returns head to 0x100. 3×WERR with stgs=2 gives stage_cnt 1, 2, 0. LOAD gives raddr_a = resreg, raddr_b = errreg.
- CLR with DATA_ADDR_W=4: 16 cycles of mem_clr_we with ram_addr_a 0..15, then mrst_done for 1 cycle. Heads are reset and cmd_ready is high after.
- Errors: cfg_we during CONV gives cfg_err and the record is unchanged. cmd_id=13 gives cmd_err. A cfg with len=0 is rejected.
- Reset mid-CONV at beat 2: the next cycle has addr_valid=0 and state IDLE, and a CONV to id2 then gives cmd_err because the vector is unconfigured.
